// File: rtl/wf_samp_wr_ctrl_pkg.sv
// ============================================================================
// Module      : wf_samp_wr_ctrl_pkg
// Description : Shared types and defaults for the waterfall sample write side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wf_samp_wr_ctrl_pkg;

    typedef logic [0:0] wf_state_t;

    localparam wf_state_t FILL = 1'b0;
    localparam wf_state_t DONE = 1'b1;

    localparam int WF_SAMP_ADDR_BITS = 13;
    localparam int WF_SAMP_DATA_BITS = 16;
    localparam int WF_SAMP_OVF_BITS  = 16;

endpackage

`default_nettype wire

// File: rtl/wf_samp_wr_ctrl.sv
// ============================================================================
// Module      : wf_samp_wr_ctrl
// Description : Waterfall sample-buffer write controller: packs I/Q, drives the
//               RAM write port, one-shot/continuous capture, pointer snapshot.
//               Optional WF_SAMP_OVF_CNT_EN adds the dropped-strobe counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wf_samp_wr_ctrl
    import wf_samp_wr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = WF_SAMP_DATA_BITS,
    parameter int ADDR_WIDTH = WF_SAMP_ADDR_BITS
) (
    input  logic                    adc_clk,
    input  logic                    rst,
    input  logic                    wr_continuous,
    input  logic                    wr_stb,
    input  logic [DATA_WIDTH-1:0]   wr_i,
    input  logic [DATA_WIDTH-1:0]   wr_q,
    input  logic                    sync_req,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_waddr,
    output logic [2*DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0]   wr_ptr,
    output logic [ADDR_WIDTH-1:0]   sync_ptr,
    output logic                    full,
    output logic                    wrapped
`ifdef WF_SAMP_OVF_CNT_EN
    ,
    output logic [WF_SAMP_OVF_BITS-1:0] ovf_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] C_PTR_MAX = {ADDR_WIDTH{1'b1}};

    wf_state_t                 state_q,  state_d;
    logic                      cont_q,   cont_d;
    logic                      we_q,     we_d;
    logic [ADDR_WIDTH-1:0]     waddr_q,  waddr_d;
    logic [2*DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic [ADDR_WIDTH-1:0]     ptr_q,    ptr_d;
    logic [ADDR_WIDTH-1:0]     sync_q,   sync_d;
    logic                      full_q,   full_d;
    logic                      wrap_q,   wrap_d;

    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        sync_d  = sync_q;
        full_d  = full_q;
        wrap_d  = wrap_q;

        if (wr_stb && (state_q == FILL)) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = {wr_i, wr_q};
            ptr_d   = ptr_q + C_PTR_ONE;
            if (ptr_q == C_PTR_MAX) begin
                if (cont_q) begin
                    wrap_d  = 1'b1;
                end else begin
                    state_d = DONE;
                    full_d  = 1'b1;
                end
            end
        end

        // Snapshot reflects this cycle's increment so the reader sees a consistent pointer.
        if (sync_req) begin
            sync_d = ptr_d;
        end
    end

    // Mode is captured only while reset is held.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state_q <= FILL;
            cont_q  <= wr_continuous;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            sync_q  <= '0;
            full_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cont_q  <= cont_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            sync_q  <= sync_d;
            full_q  <= full_d;
            wrap_q  <= wrap_d;
        end
    end

    assign ram_we    = we_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;
    assign wr_ptr    = ptr_q;
    assign sync_ptr  = sync_q;
    assign full      = full_q;
    assign wrapped   = wrap_q;

`ifdef WF_SAMP_OVF_CNT_EN
    localparam logic [WF_SAMP_OVF_BITS-1:0] C_OVF_ONE = {{(WF_SAMP_OVF_BITS-1){1'b0}}, 1'b1};

    logic [WF_SAMP_OVF_BITS-1:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_stb && (state_q == DONE) && (ovf_q != {WF_SAMP_OVF_BITS{1'b1}})) begin
            ovf_d = ovf_q + C_OVF_ONE;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_cnt = ovf_q;
`endif

endmodule

`default_nettype wire
